// File: rtl/and_gate_pkg.sv
// Shared encodings for the and_gate_unit slice: truth-table coverage indices.
package and_gate_pkg;

  localparam int unsigned COMBO_00 = 0;
  localparam int unsigned COMBO_01 = 1;
  localparam int unsigned COMBO_10 = 2;
  localparam int unsigned COMBO_11 = 3;
  localparam int unsigned COV_W    = 4;

endpackage : and_gate_pkg

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; synchronous clear has priority over increment.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule : sat_counter

// File: rtl/and_gate_unit.sv
// Bitwise AND with combinational and registered outputs, sticky truth-table
// coverage and a saturating count of cycles with a nonzero result.
module and_gate_unit
  import and_gate_pkg::*;
#(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q,
  output logic [COV_W-1:0] cov,
  output logic [CNT_W-1:0] hi_cnt
);

  logic [WIDTH-1:0] m00, m01, m10, m11;
  logic [COV_W-1:0] hit;

  // Combinational path stays live during reset and without a clock.
  assign y = a & b;

  // Per-bit truth-table match, later OR-reduced per combination.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign m00[i] = ({a[i], b[i]} == 2'(COMBO_00));
    assign m01[i] = ({a[i], b[i]} == 2'(COMBO_01));
    assign m10[i] = ({a[i], b[i]} == 2'(COMBO_10));
    assign m11[i] = ({a[i], b[i]} == 2'(COMBO_11));
  end

  assign hit[COMBO_00] = |m00;
  assign hit[COMBO_01] = |m01;
  assign hit[COMBO_10] = |m10;
  assign hit[COMBO_11] = |m11;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q <= '0;
      cov <= '0;
    end else begin
      y_q <= a & b;
      cov <= clr ? '0 : (cov | hit);
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_hi_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (|y),
    .clr   (clr),
    .cnt   (hi_cnt)
  );

endmodule : and_gate_unit

// File: tb/tb_and_gate_unit.sv
// Directed checks of and_gate_unit at WIDTH=1/CNT_W=16, WIDTH=1/CNT_W=2 and WIDTH=4.
module tb_and_gate_unit;

  logic clk = 1'b0;
  logic clk_en = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;

  logic        a1 = 1'b0, b1 = 1'b0;
  logic        y1, yq1;
  logic [3:0]  cov1;
  logic [15:0] hi1;

  logic        a2 = 1'b0, b2 = 1'b0;
  logic        y2, yq2;
  logic [3:0]  cov2;
  logic [1:0]  hi2;

  logic [3:0]  a4 = 4'b0, b4 = 4'b0;
  logic [3:0]  y4, yq4;
  logic [3:0]  cov4;
  logic [15:0] hi4;

  int checks = 0;
  int errors = 0;

  and_gate_unit #(.WIDTH(1), .CNT_W(16)) u_w1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .a(a1), .b(b1),
    .y(y1), .y_q(yq1), .cov(cov1), .hi_cnt(hi1)
  );

  and_gate_unit #(.WIDTH(1), .CNT_W(2)) u_c2 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .a(a2), .b(b2),
    .y(y2), .y_q(yq2), .cov(cov2), .hi_cnt(hi2)
  );

  and_gate_unit #(.WIDTH(4), .CNT_W(16)) u_w4 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .a(a4), .b(b4),
    .y(y4), .y_q(yq4), .cov(cov4), .hi_cnt(hi4)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Short reset pulse placed between edges; next posedge is the first live edge.
  task automatic rst_pulse();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  task automatic edge_settle();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] t1_ab [4]  = '{2'b00, 2'b01, 2'b10, 2'b11};
  logic       t1_y  [4]  = '{1'b0, 1'b0, 1'b0, 1'b1};
  logic [3:0] t3_cov [4] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};
  logic [1:0] t4_hi [5]  = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

  initial begin
    // 1: combinational truth table, no clock
    #100;
    for (int i = 0; i < 4; i++) begin
      {a1, b1} = t1_ab[i];
      #1;
      check($sformatf("t1_y_%0d", i), 32'(y1), 32'(t1_y[i]));
    end

    // 2: reset held with a=b=1, then release
    a1 = 1'b1; b1 = 1'b1;
    #1;
    check("t2_y_in_rst", 32'(y1), 32'd1);
    check("t2_yq_in_rst", 32'(yq1), 32'd0);
    check("t2_cov_in_rst", 32'(cov1), 32'd0);
    check("t2_hi_in_rst", 32'(hi1), 32'd0);
    clk_en = 1'b1;
    edge_settle();
    check("t2_yq_rst_edge", 32'(yq1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    edge_settle();
    check("t2_yq", 32'(yq1), 32'd1);
    check("t2_cov", 32'(cov1), 32'b1000);
    check("t2_hi", 32'(hi1), 32'd1);

    // 3: walk all four combinations from a fresh reset
    rst_pulse();
    for (int i = 0; i < 4; i++) begin
      {a1, b1} = t1_ab[i];
      edge_settle();
      check($sformatf("t3_cov_%0d", i), 32'(cov1), 32'(t3_cov[i]));
      check($sformatf("t3_yq_%0d", i), 32'(yq1), 32'(t1_y[i]));
      @(negedge clk);
    end
    check("t3_hi", 32'(hi1), 32'd1);

    // 4: 2-bit counter saturation and clear
    rst_pulse();
    a2 = 1'b1; b2 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      edge_settle();
      check($sformatf("t4_hi_%0d", i), 32'(hi2), 32'(t4_hi[i]));
    end
    check("t4_cov_pre_clr", 32'(cov2), 32'b1000);
    @(negedge clk);
    clr = 1'b1;
    edge_settle();
    check("t4_hi_clr", 32'(hi2), 32'd0);
    check("t4_cov_clr", 32'(cov2), 32'd0);
    check("t4_yq_clr", 32'(yq2), 32'd1);
    @(negedge clk);
    clr = 1'b0;
    edge_settle();
    check("t4_hi_after_clr", 32'(hi2), 32'd1);

    // 5: WIDTH=4 mixed operand, every combination in one sample
    rst_pulse();
    a4 = 4'b1100; b4 = 4'b1010;
    #1;
    check("t5_y", 32'(y4), 32'b1000);
    edge_settle();
    check("t5_yq", 32'(yq4), 32'b1000);
    check("t5_cov", 32'(cov4), 32'b1111);
    check("t5_hi", 32'(hi4), 32'd1);

    // 6: asynchronous reset between edges
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_yq", 32'(yq4), 32'd0);
    check("t6_cov", 32'(cov4), 32'd0);
    check("t6_hi", 32'(hi4), 32'd0);
    check("t6_hi_c2", 32'(hi2), 32'd0);
    check("t6_y", 32'(y4), 32'b1000);
    a4 = 4'b0110; b4 = 4'b0011;
    #1;
    check("t6_y_track", 32'(y4), 32'b0010);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule : tb_and_gate_unit
